ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED Set-LEDs, 0xF0 scan-code-set, 0xFF reset) from the FPGA to the keyboard over the same PS2_CLK/PS2_DATA pair that `keyboard_ps2` receives on. It sits beside `keyboard_ps2` under `top`, and the board-level open-drain buffers are driven from its `*_oe` outputs. `busy` gates the receiver so it ignores host-generated activity.

## Interface
- `INHIBIT_CYCLES`, default 5000: clock-inhibit length in `clk` cycles (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum transfer duration in cycles, counted from clock release (15 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz (CLK50MHZ).
- `resetn`  in  1  synchronous, active-low reset.
- `tx_data`  in  8  byte to send, LSB first.
- `tx_valid`  in  1  request; accepted when `tx_valid && tx_ready`.
- `tx_ready`  out  1  high only in IDLE.
- `ps2_clk_in`  in  1  raw PS2_CLK pin level (asynchronous).
- `ps2_data_in`  in  1  raw PS2_DATA pin level (asynchronous).
- `ps2_clk_oe`  out  1  1 = pull PS2_CLK low; 0 = release.
- `ps2_data_oe`  out  1  1 = pull PS2_DATA low; 0 = release.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a transfer completes normally.
- `ack_ok`  out  1  valid with `done`; 1 = device acked (data low at the 11th falling edge). Held until the next accept.
- `err`  out  1  one-cycle pulse on timeout.

## Operation
- `ps2_clk_in` and `ps2_data_in` pass through 2-flop synchronizers. A falling edge is prev_sync=1 and cur_sync=0.
- The byte is latched at accept. Parity is odd: `par = ~^tx_data`. A 4-bit edge counter `n` counts falling edges.
- States:
  - **IDLE:** both `oe` outputs are 0. On accept, go to INHIBIT and clear `ack_ok`.
  - **INHIBIT:** `ps2_clk_oe`=1 and `ps2_data_oe`=0 for exactly INHIBIT_CYCLES cycles, then go to REQ.
  - **REQ:** one cycle with `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit). Then go to XFER with `n`=0 and the timeout counter cleared.
  - **XFER:** `ps2_clk_oe`=0.
    - Before edge 1, `ps2_data_oe`=1.
    - On falling edge k (k=1..8), `ps2_data_oe` becomes `~tx_data[k-1]`.
    - On edge 9 it becomes `~par`.
    - On edge 10 it becomes 0 (stop, line released).
    - On edge 11, sample synced data: `ack_ok` = ~data. Then go to WAITIDLE.
  - **WAITIDLE:** both `oe` outputs are 0. When synced clk=1 and data=1, pulse `done` and go to IDLE.
- Timeout: the counter runs in XFER and WAITIDLE. Reaching TIMEOUT_CYCLES-1 releases both lines, pulses `err` (no `done`) and goes to IDLE.
- `tx_valid` while not IDLE is ignored; nothing is queued.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_ready`=1, `busy`=0, `done`=0, `ack_ok`=0, `err`=0, state IDLE.
- Reset mid-transfer releases both lines on the next edge with no `done`/`err` pulse.
- Accept at edge T gives `ps2_clk_oe`=1 from T+1 through T+INHIBIT_CYCLES. `ps2_data_oe` rises at T+INHIBIT_CYCLES+1 and `ps2_clk_oe` falls at T+INHIBIT_CYCLES+2.
- Data updates exactly 3 cycles after the pin's falling edge (2 synchronizer stages + 1 register). This is far inside the ~30 µs clock-low time, so the bit is stable before the device samples on the rising edge.
- `done` is asserted 3 cycles after both pins read high, and `tx_ready` returns on the cycle after `done`.
- Edges arriving in INHIBIT/REQ are ignored because the host is driving the clock. If the timeout and edge 11 occur in the same cycle, the timeout wins.
- `oe` outputs are registered, with no combinational path from the inputs.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and acking. Required: bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop released, `done` pulse, `ack_ok`=1, `err`=0.
- Send 0x07 then 0xFF back-to-back, with `tx_valid` held high. Required: parity 0 for 0x07 and 1 for 0xFF. Second inhibit starts one cycle after `tx_ready` returns.
- Device never clocks, with TIMEOUT_CYCLES=2000 and INHIBIT_CYCLES=50. Required: `err` pulses exactly 2000 cycles after REQ ends, lines are released, and `done` never pulses.
- Device leaves data high at edge 11. Required: `done`=1 with `ack_ok`=0.
- Pulse `tx_valid` with 0x55 during XFER of 0xF0. Required: ignored, only 0xF0 on the wire, and `tx_ready`=0 throughout.
- Assert `resetn`=0 for 1 cycle after edge 5. Required: `oe` outputs are 0 the next cycle, `tx_ready`=1, and no `done`/`err` pulse.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : Host-to-device PS/2 command transmitter (inhibit, request,
//             bit-serial send on device clock, ack sample, idle wait).
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_INHIBIT  = 3'd1;
    localparam logic [2:0] c_ST_REQ      = 3'd2;
    localparam logic [2:0] c_ST_XFER     = 3'd3;
    localparam logic [2:0] c_ST_WAITIDLE = 3'd4;

    localparam int c_MAX_CNT = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
    localparam logic [c_CNT_W-1:0] c_INH_LAST = c_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TO_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_n;
    logic [7:0]         r_data;
    logic               r_par;
    logic               r_clk_meta, r_clk_sync, r_clk_prev;
    logic               r_data_meta, r_data_sync;
    logic               r_clk_oe, r_data_oe, r_done, r_ack_ok, r_err;

    logic               w_accept;
    logic               w_fall;
    logic               w_timeout;
    logic [3:0]         w_n_next;

    // tx_ready stays low during the done pulse so a held tx_valid re-accepts one cycle later
    assign tx_ready    = (r_state == c_ST_IDLE) && !r_done;
    assign busy        = (r_state != c_ST_IDLE);
    assign w_accept    = tx_valid && tx_ready;
    assign w_fall      = r_clk_prev && !r_clk_sync;
    assign w_timeout   = (r_cnt == c_TO_LAST);
    assign w_n_next    = r_n + 4'd1;

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign ack_ok      = r_ack_ok;
    assign err         = r_err;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_n         <= 4'd0;
            r_data      <= 8'd0;
            r_par       <= 1'b0;
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
            r_done      <= 1'b0;
            r_ack_ok    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_clk_meta  <= ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_in;
            r_data_sync <= r_data_meta;
            r_done      <= 1'b0;
            r_err       <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (w_accept) begin
                        r_state  <= c_ST_INHIBIT;
                        r_data   <= tx_data;
                        r_par    <= ~^tx_data;
                        r_ack_ok <= 1'b0;
                        r_clk_oe <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                c_ST_INHIBIT: begin
                    if (r_cnt == c_INH_LAST) begin
                        r_state   <= c_ST_REQ;
                        r_data_oe <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_REQ: begin
                    r_state  <= c_ST_XFER;
                    r_clk_oe <= 1'b0;
                    r_n      <= 4'd0;
                    r_cnt    <= '0;
                end
                c_ST_XFER: begin
                    if (w_timeout) begin
                        r_state   <= c_ST_IDLE;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_fall) begin
                            r_n <= w_n_next;
                            if (w_n_next <= 4'd8) begin
                                r_data_oe <= ~r_data[r_n[2:0]];
                            end else if (w_n_next == 4'd9) begin
                                r_data_oe <= ~r_par;
                            end else if (w_n_next == 4'd10) begin
                                r_data_oe <= 1'b0;
                            end else begin
                                r_ack_ok  <= ~r_data_sync;
                                r_data_oe <= 1'b0;
                                r_state   <= c_ST_WAITIDLE;
                            end
                        end
                    end
                end
                c_ST_WAITIDLE: begin
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                    if (w_timeout) begin
                        r_state <= c_ST_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_clk_sync && r_data_sync) begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state   <= c_ST_IDLE;
                    r_clk_oe  <= 1'b0;
                    r_data_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
